// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed when the operation starts and held in a temp
// register. A down-counter then models the pipeline latency, and the
// result commits to HI/LO when the count expires.
module mult_div_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [63:0]        temp, temp_next;
    logic [31:0]        hi_q, hi_next;
    logic [31:0]        lo_q, lo_next;
    logic               busy_q, busy_next;

    // 64-bit product; sign-extending the operands for the signed case makes
    // the low 64 bits of the wide product the correct two's-complement result.
    function automatic logic [63:0] mul_op(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}. The signed path is evaluated at 64 bits.
    // This keeps 0x80000000 / -1 from overflowing: the quotient wraps to
    // 0x80000000 and the remainder is 0. The divisor is never zero here.
    function automatic logic [63:0] div_op(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
        logic signed [63:0] as;
        logic signed [63:0] bs;
        logic signed [63:0] qs;
        logic signed [63:0] rs;
        logic [31:0]        qu;
        logic [31:0]        ru;
        if (sgn) begin
            as = $signed({{32{a[31]}}, a});
            bs = $signed({{32{b[31]}}, b});
            qs = as / bs;
            rs = as % bs;
            return {rs[31:0], qs[31:0]};
        end else begin
            qu = a / b;
            ru = a % b;
            return {ru, qu};
        end
    endfunction

    // Next-state, counter, temp and HI/LO update decode
    always_comb begin
        state_next = state;
        count_next = count;
        temp_next  = temp;
        hi_next    = hi_q;
        lo_next    = lo_q;
        busy_next  = busy_q;
        case (state)
            IDLE: begin
                case (MDOp)
                    OP_MULT, OP_MULTU: begin
                        temp_next  = mul_op(A, B, MDOp == OP_MULT);
                        count_next = CNT_W'(MULT_CYC);
                        state_next = MULT;
                        busy_next  = 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        // A zero divisor reloads the current HI/LO so the
                        // commit leaves them unchanged.
                        if (B == 32'd0) begin
                            temp_next = {hi_q, lo_q};
                        end else begin
                            temp_next = div_op(A, B, MDOp == OP_DIV);
                        end
                        count_next = CNT_W'(DIV_CYC);
                        state_next = DIV;
                        busy_next  = 1'b1;
                    end
                    OP_MTHI: hi_next = A;
                    OP_MTLO: lo_next = A;
                    default: ;
                endcase
            end
            MULT, DIV: begin
                if (count == CNT_W'(1)) begin
                    hi_next    = temp[63:32];
                    lo_next    = temp[31:0];
                    count_next = '0;
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset of all storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            temp   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            temp   <= temp_next;
            hi_q   <= hi_next;
            lo_q   <= lo_next;
            busy_q <= busy_next;
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = busy_q;
    assign Stall = busy_q | ((MDOp >= OP_MULT) && (MDOp <= OP_DIVU));

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Stall;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B),
        .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MDOp = 3'b001; A = 32'd1; B = 32'd1;
        #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL reset_stall_decode got %b exp 1", Stall); end
        step(); step();
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", LO); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        MDOp = 3'b000; #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b exp 0", Stall); end
        reset = 1'b0;
        step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", Busy); end
    endtask

    // Start an op, check Busy/Stall for n cycles, then check the committed result
    task automatic test_op(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int n, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        MDOp = op; A = a; B = b; #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL %s_start_stall got %b exp 1", name, Stall); end
        step();
        MDOp = 3'b000; A = 32'h0; B = 32'h0; #1;
        for (int i = 1; i <= n; i++) begin
            checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL %s_busy_c%0d got %b exp 1", name, i, Busy); end
            checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL %s_stall_c%0d got %b exp 1", name, i, Stall); end
            step();
        end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b exp 0", name, Busy); end
        checks++; if (HI !== exp_hi) begin errors++; $display("FAIL %s_hi got %h exp %h", name, HI, exp_hi); end
        checks++; if (LO !== exp_lo) begin errors++; $display("FAIL %s_lo got %h exp %h", name, LO, exp_lo); end
    endtask

    task automatic test_arith();
        test_op("mult",  3'b001, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        test_op("multu", 3'b010, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        test_op("div",   3'b011, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("divu",  3'b100, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
        test_op("divovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        test_op("divpos", 3'b011, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    endtask

    task automatic test_mthi_mtlo_divzero();
        MDOp = 3'b101; A = 32'h12345678; step();
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi got %h exp 12345678", HI); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", Busy); end
        MDOp = 3'b110; A = 32'hCAFEF00D; step();
        checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo got %h exp cafef00d", LO); end
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mtlo_keeps_hi got %h exp 12345678", HI); end
        MDOp = 3'b000;
        test_op("divu0", 3'b100, 32'h55555555, 32'd0, 10, 32'h12345678, 32'hCAFEF00D);
        test_op("div0",  3'b011, 32'h80000000, 32'd0, 10, 32'h12345678, 32'hCAFEF00D);
    endtask

    task automatic test_nop();
        MDOp = 3'b000; A = 32'hAAAAAAAA; B = 32'h1; #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL nop0_stall got %b exp 0", Stall); end
        step();
        MDOp = 3'b111; #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL nop7_stall got %b exp 0", Stall); end
        step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL nop_busy got %b exp 0", Busy); end
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL nop_hi got %h exp 12345678", HI); end
        checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL nop_lo got %h exp cafef00d", LO); end
        MDOp = 3'b000;
    endtask

    task automatic test_busy_ignore();
        MDOp = 3'b010; A = 32'h00010000; B = 32'h00010000; step();
        MDOp = 3'b000; step();
        MDOp = 3'b110; A = 32'hDEADBEEF; step();
        MDOp = 3'b001; A = 32'd3; B = 32'd3; step();
        MDOp = 3'b000; #1;
        checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL ignore_lo_busy got %h exp cafef00d", LO); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_c4 got %b exp 1", Busy); end
        step();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_c5 got %b exp 1", Busy); end
        step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got %b exp 0", Busy); end
        checks++; if (HI !== 32'h00000001) begin errors++; $display("FAIL ignore_hi got %h exp 00000001", HI); end
        checks++; if (LO !== 32'h00000000) begin errors++; $display("FAIL ignore_lo got %h exp 00000000", LO); end
    endtask

    task automatic test_reset_abort();
        MDOp = 3'b101; A = 32'hA5A5A5A5; step();
        MDOp = 3'b110; A = 32'h5A5A5A5A; step();
        MDOp = 3'b011; A = 32'd100; B = 32'd7; step();
        MDOp = 3'b000; step(); step(); step();
        reset = 1'b1; MDOp = 3'b001; #1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_busy_c4 got %b exp 1", Busy); end
        step();
        reset = 1'b0; MDOp = 3'b000; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", Busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL abort_hi got %h exp 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL abort_lo got %h exp 00000000", LO); end
        test_op("after_abort", 3'b001, 32'd6, 32'd7, 5, 32'h00000000, 32'd42);
    endtask

    task automatic test_back_to_back();
        test_op("b2b_mult", 3'b001, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
        test_op("b2b_divu", 3'b100, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        MDOp = 3'b101; A = 32'h11111111; step();
        MDOp = 3'b110; A = 32'h22222222; step();
        MDOp = 3'b000;
        checks++; if (HI !== 32'h11111111) begin errors++; $display("FAIL b2b_mthi got %h exp 11111111", HI); end
        checks++; if (LO !== 32'h22222222) begin errors++; $display("FAIL b2b_mtlo got %h exp 22222222", LO); end
    endtask

    initial begin
        reset = 1'b1; MDOp = 3'b000; A = 32'h0; B = 32'h0;
        test_reset();
        test_arith();
        test_mthi_mtlo_divzero();
        test_nop();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
